// File: rtl/req_port_arb.sv
// rtl/req_port_arb.sv - two-master arbiter for a shared burst request port
module req_port_arb #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // master 0
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_req_we,
    input  logic [2:0]  m0_req_len,
    input  logic [3:0]  m0_req_mask,
    input  logic [31:0] m0_req_addr,
    input  logic        m0_write_valid,
    output logic        m0_write_ready,
    input  logic [31:0] m0_write_data,
    output logic        m0_read_valid,
    output logic [31:0] m0_read_data,
    input  logic        m0_read_ack,
    // master 1
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_req_we,
    input  logic [2:0]  m1_req_len,
    input  logic [3:0]  m1_req_mask,
    input  logic [31:0] m1_req_addr,
    input  logic        m1_write_valid,
    output logic        m1_write_ready,
    input  logic [31:0] m1_write_data,
    output logic        m1_read_valid,
    output logic [31:0] m1_read_data,
    input  logic        m1_read_ack,
    // slave
    output logic        s_req_valid,
    input  logic        s_req_ready,
    output logic        s_req_we,
    output logic [2:0]  s_req_len,
    output logic [3:0]  s_req_mask,
    output logic [31:0] s_req_addr,
    output logic        s_write_valid,
    input  logic        s_write_ready,
    output logic [31:0] s_write_data,
    input  logic        s_read_valid,
    input  logic [31:0] s_read_data,
    output logic        s_read_ack,
    // current owner {m1,m0}
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    state_t      state, state_d;
    logic [1:0]  grant_d;
    logic        ptr, ptr_d;          // 0: m0 wins next tie, 1: m1 wins next tie
    logic [2:0]  cnt, cnt_d;          // remaining beats minus one
    logic        req_we_d;
    logic [2:0]  req_len_d;
    logic [3:0]  req_mask_d;
    logic [31:0] req_addr_d;
    logic        pick_m1;
    logic        wr_valid_g;
    logic        rd_ack_g;

    // Read data fans out to both masters; only read_valid is qualified by grant.
    assign m0_read_data = s_read_data;
    assign m1_read_data = s_read_data;

    // Tie winner: m1 under fixed priority, otherwise whoever the pointer names.
    assign pick_m1 = (m0_req_valid && m1_req_valid) ? (FIXED_PRIO ? 1'b1 : ptr)
                                                     : m1_req_valid;

    assign wr_valid_g = grant[1] ? m1_write_valid : m0_write_valid;
    assign rd_ack_g   = grant[1] ? m1_read_ack    : m0_read_ack;

    // State, grant, pointer, beat counter and latched request fields.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            grant      <= 2'b00;
            ptr        <= 1'b0;
            cnt        <= 3'd0;
            s_req_we   <= 1'b0;
            s_req_len  <= 3'd0;
            s_req_mask <= 4'd0;
            s_req_addr <= 32'd0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            ptr        <= ptr_d;
            cnt        <= cnt_d;
            s_req_we   <= req_we_d;
            s_req_len  <= req_len_d;
            s_req_mask <= req_mask_d;
            s_req_addr <= req_addr_d;
        end
    end

    // Next-state logic and per-state steering of handshakes between master and slave.
    always_comb begin
        state_d        = state;
        grant_d        = grant;
        ptr_d          = ptr;
        cnt_d          = cnt;
        req_we_d       = s_req_we;
        req_len_d      = s_req_len;
        req_mask_d     = s_req_mask;
        req_addr_d     = s_req_addr;
        s_req_valid    = 1'b0;
        s_write_valid  = 1'b0;
        s_write_data   = grant[1] ? m1_write_data : m0_write_data;
        s_read_ack     = 1'b0;
        m0_req_ready   = 1'b0;
        m1_req_ready   = 1'b0;
        m0_write_ready = 1'b0;
        m1_write_ready = 1'b0;
        m0_read_valid  = 1'b0;
        m1_read_valid  = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req_valid || m1_req_valid) begin
                    state_d    = REQ;
                    grant_d    = pick_m1 ? 2'b10 : 2'b01;
                    req_we_d   = pick_m1 ? m1_req_we   : m0_req_we;
                    req_len_d  = pick_m1 ? m1_req_len  : m0_req_len;
                    req_mask_d = pick_m1 ? m1_req_mask : m0_req_mask;
                    req_addr_d = pick_m1 ? m1_req_addr : m0_req_addr;
                end
            end
            REQ: begin
                s_req_valid = 1'b1;
                if (s_req_ready) begin
                    m0_req_ready = grant[0];
                    m1_req_ready = grant[1];
                    cnt_d        = s_req_len;
                    state_d      = s_req_we ? WDATA : RDATA;
                end
            end
            WDATA: begin
                s_write_valid  = wr_valid_g;
                m0_write_ready = s_write_ready & grant[0];
                m1_write_ready = s_write_ready & grant[1];
                if (wr_valid_g && s_write_ready) begin
                    if (cnt == 3'd0) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        ptr_d   = grant[0];
                    end else begin
                        cnt_d = cnt - 3'd1;
                    end
                end
            end
            RDATA: begin
                m0_read_valid = s_read_valid & grant[0];
                m1_read_valid = s_read_valid & grant[1];
                s_read_ack    = rd_ack_g;
                if (s_read_valid && rd_ack_g) begin
                    if (cnt == 3'd0) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        ptr_d   = grant[0];
                    end else begin
                        cnt_d = cnt - 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_req_port_arb.sv
// tb/tb_req_port_arb.sv - scoreboard bench for req_port_arb
module tb_req_port_arb;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m0_req_valid = 0, m0_req_we = 0, m0_write_valid = 0, m0_read_ack = 0;
    logic [2:0]  m0_req_len = 0;
    logic [3:0]  m0_req_mask = 0;
    logic [31:0] m0_req_addr = 0, m0_write_data = 0;
    logic        m1_req_valid = 0, m1_req_we = 0, m1_write_valid = 0, m1_read_ack = 0;
    logic [2:0]  m1_req_len = 0;
    logic [3:0]  m1_req_mask = 0;
    logic [31:0] m1_req_addr = 0, m1_write_data = 0;
    logic        s_req_ready = 0, s_write_ready = 0, s_read_valid = 0;
    logic [31:0] s_read_data = 0;

    logic        m0_req_ready, m0_write_ready, m0_read_valid;
    logic        m1_req_ready, m1_write_ready, m1_read_valid;
    logic [31:0] m0_read_data, m1_read_data;
    logic        s_req_valid, s_req_we, s_write_valid, s_read_ack;
    logic [2:0]  s_req_len;
    logic [3:0]  s_req_mask;
    logic [31:0] s_req_addr, s_write_data;
    logic [1:0]  grant;

    logic        fp_m0_req_valid = 0, fp_m1_req_valid = 0;
    logic        fp_m0_req_ready, fp_m0_write_ready, fp_m0_read_valid;
    logic        fp_m1_req_ready, fp_m1_write_ready, fp_m1_read_valid;
    logic [31:0] fp_m0_read_data, fp_m1_read_data;
    logic        fp_s_req_valid, fp_s_req_we, fp_s_write_valid, fp_s_read_ack;
    logic [2:0]  fp_s_req_len;
    logic [3:0]  fp_s_req_mask;
    logic [31:0] fp_s_req_addr, fp_s_write_data;
    logic [1:0]  fp_grant;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        we;
        logic [2:0]  len;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [1:0]  grant;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_rd0_q[$];
    logic [31:0] exp_rd1_q[$];
    logic [35:0] exp_wr_q[$];
    req_t        mon_req;
    logic [35:0] mon_wr;
    logic [31:0] mon_rd;

    always #5 clk = ~clk;

    req_port_arb #(.FIXED_PRIO(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_len(m0_req_len), .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr),
        .m0_write_valid(m0_write_valid), .m0_write_ready(m0_write_ready), .m0_write_data(m0_write_data),
        .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data), .m0_read_ack(m0_read_ack),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_len(m1_req_len), .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr),
        .m1_write_valid(m1_write_valid), .m1_write_ready(m1_write_ready), .m1_write_data(m1_write_data),
        .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data), .m1_read_ack(m1_read_ack),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_len(s_req_len), .s_req_mask(s_req_mask), .s_req_addr(s_req_addr),
        .s_write_valid(s_write_valid), .s_write_ready(s_write_ready), .s_write_data(s_write_data),
        .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(s_read_ack),
        .grant(grant)
    );

    // Fixed-priority instance with an always-ready slave and single-beat reads.
    req_port_arb #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_req_valid(fp_m0_req_valid), .m0_req_ready(fp_m0_req_ready), .m0_req_we(1'b0),
        .m0_req_len(3'd0), .m0_req_mask(4'd0), .m0_req_addr(32'd0),
        .m0_write_valid(1'b0), .m0_write_ready(fp_m0_write_ready), .m0_write_data(32'd0),
        .m0_read_valid(fp_m0_read_valid), .m0_read_data(fp_m0_read_data), .m0_read_ack(1'b1),
        .m1_req_valid(fp_m1_req_valid), .m1_req_ready(fp_m1_req_ready), .m1_req_we(1'b0),
        .m1_req_len(3'd0), .m1_req_mask(4'd0), .m1_req_addr(32'd0),
        .m1_write_valid(1'b0), .m1_write_ready(fp_m1_write_ready), .m1_write_data(32'd0),
        .m1_read_valid(fp_m1_read_valid), .m1_read_data(fp_m1_read_data), .m1_read_ack(1'b1),
        .s_req_valid(fp_s_req_valid), .s_req_ready(1'b1), .s_req_we(fp_s_req_we),
        .s_req_len(fp_s_req_len), .s_req_mask(fp_s_req_mask), .s_req_addr(fp_s_req_addr),
        .s_write_valid(fp_s_write_valid), .s_write_ready(1'b1), .s_write_data(fp_s_write_data),
        .s_read_valid(1'b1), .s_read_data(32'd0), .s_read_ack(fp_s_read_ack),
        .grant(fp_grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every completed handshake, mid-cycle.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (s_req_valid && s_req_ready) begin
                if (exp_req_q.size() == 0) chk("req_unexpected", 1, 0);
                else begin
                    mon_req = exp_req_q.pop_front();
                    chk("req_fields", {s_req_we, s_req_len, s_req_mask, s_req_addr, grant}, mon_req);
                end
            end
            if (m0_read_valid && m0_read_ack) begin
                if (exp_rd0_q.size() == 0) chk("rd0_unexpected", 1, 0);
                else begin
                    mon_rd = exp_rd0_q.pop_front();
                    chk("rd0_data", m0_read_data, mon_rd);
                end
            end
            if (m1_read_valid && m1_read_ack) begin
                if (exp_rd1_q.size() == 0) chk("rd1_unexpected", 1, 0);
                else begin
                    mon_rd = exp_rd1_q.pop_front();
                    chk("rd1_data", m1_read_data, mon_rd);
                end
            end
            if (s_write_valid && s_write_ready) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    mon_wr = exp_wr_q.pop_front();
                    chk("wr_beat", {grant, s_write_data, m0_write_ready, m1_write_ready}, mon_wr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {grant, s_req_valid, s_write_valid, s_read_ack, m0_req_ready, m1_req_ready,
                   m0_write_ready, m1_write_ready, m0_read_valid, m1_read_valid,
                   s_req_we, s_req_len, s_req_mask}, 0);
        chk({name, "_addr"}, s_req_addr, 0);
    endtask

    task automatic issue(input bit m, input bit we, input logic [2:0] len,
                         input logic [3:0] mask, input logic [31:0] addr);
        req_t e;
        e.we = we; e.len = len; e.mask = mask; e.addr = addr;
        e.grant = m ? 2'b10 : 2'b01;
        exp_req_q.push_back(e);
        if (m) begin
            m1_req_valid = 1; m1_req_we = we; m1_req_len = len; m1_req_mask = mask; m1_req_addr = addr;
        end else begin
            m0_req_valid = 1; m0_req_we = we; m0_req_len = len; m0_req_mask = mask; m0_req_addr = addr;
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!s_req_valid && n < 20) begin
            step();
            n++;
        end
        chk({name, "_req_seen"}, s_req_valid, 1);
    endtask

    task automatic handshake(input bit m, input string name);
        wait_req(name);
        s_req_ready = 1;
        #1;
        chk({name, "_req_ready"}, {m1_req_ready, m0_req_ready}, m ? 2'b10 : 2'b01);
        step();
        s_req_ready = 0;
        if (m) m1_req_valid = 0; else m0_req_valid = 0;
    endtask

    task automatic rd_beats(input bit m, input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            s_read_valid = 1;
            s_read_data  = base + i;
            if (m) begin m1_read_ack = 1; exp_rd1_q.push_back(base + i); end
            else   begin m0_read_ack = 1; exp_rd0_q.push_back(base + i); end
            step();
        end
        s_read_valid = 0; m0_read_ack = 0; m1_read_ack = 0;
    endtask

    task automatic serve_read(input bit m, input int len, input logic [31:0] base, input string name);
        handshake(m, name);
        rd_beats(m, len + 1, base);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int seen;

        // Reset state
        rst_ni = 0;
        step(); step(); step();
        chk_reset_outputs("reset_state");
        chk("reset_fp_grant", fp_grant, 0);
        rst_ni = 1;
        step();

        // Fixed priority: m1 wins repeated ties
        fp_m0_req_valid = 1; fp_m1_req_valid = 1;
        seen = 0;
        for (int i = 0; i < 12 && seen < 2; i++) begin
            step();
            if (fp_s_req_valid) begin
                chk("fp_tie_winner", fp_grant, 2'b10);
                seen++;
            end
        end
        chk("fp_ties_seen", seen, 2);
        fp_m0_req_valid = 0; fp_m1_req_valid = 0;

        // Test 1: m0 read len=3
        rst_ni = 0; step(); rst_ni = 1;
        issue(0, 0, 3'd3, 4'hF, 32'h0000_1000);
        step();
        chk("t1_req_latency", s_req_valid, 1);
        chk("t1_grant", grant, 2'b01);
        handshake(0, "t1");
        for (int i = 0; i < 4; i++) begin
            s_read_valid = 1; s_read_data = 32'hA000_0000 + i; m0_read_ack = 1;
            exp_rd0_q.push_back(32'hA000_0000 + i);
            #1;
            chk("t1_m1_read_valid", m1_read_valid, 0);
            step();
        end
        s_read_valid = 0; m0_read_ack = 0;
        chk("t1_grant_released", grant, 2'b00);

        // Test 2: round-robin ties after reset
        rst_ni = 0; step(); rst_ni = 1;
        issue(0, 0, 3'd0, 4'hF, 32'h0000_2000);
        issue(1, 0, 3'd0, 4'h3, 32'h0000_3000);
        serve_read(0, 0, 32'hB000_0000, "t2a");
        serve_read(1, 0, 32'hB100_0000, "t2b");
        issue(0, 0, 3'd1, 4'h1, 32'h0000_2100);
        issue(1, 0, 3'd0, 4'h2, 32'h0000_3100);
        serve_read(0, 1, 32'hB200_0000, "t2c");
        serve_read(1, 0, 32'hB300_0000, "t2d");

        // Test 3: m1 raised during beat 2 of an m0 len=7 read
        issue(0, 0, 3'd7, 4'hF, 32'h0000_4000);
        handshake(0, "t3");
        for (int i = 0; i < 8; i++) begin
            s_read_valid = 1; s_read_data = 32'hC000_0000 + i; m0_read_ack = 1;
            exp_rd0_q.push_back(32'hC000_0000 + i);
            if (i == 1) issue(1, 0, 3'd0, 4'hC, 32'h0000_5000);
            #1;
            chk("t3_no_m1_req", s_req_valid, 0);
            step();
        end
        s_read_valid = 0; m0_read_ack = 0;
        chk("t3_idle_gap", {s_req_valid, grant}, 3'b000);
        step();
        chk("t3_m1_req", {s_req_valid, grant}, 3'b110);
        serve_read(1, 0, 32'hC100_0000, "t3b");

        // Test 4: m1 single write with delayed s_write_ready
        issue(1, 1, 3'd0, 4'b0011, 32'h0000_6000);
        m1_write_valid = 1; m1_write_data = 32'hDEAD_BEEF;
        handshake(1, "t4");
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_wait", {s_write_valid, s_write_data, m1_write_ready}, {1'b1, 32'hDEAD_BEEF, 1'b0});
            step();
        end
        exp_wr_q.push_back({2'b10, 32'hDEAD_BEEF, 1'b0, 1'b1});
        s_write_ready = 1;
        #1;
        chk("t4_write_ready", m1_write_ready, 1);
        step();
        s_write_ready = 0; m1_write_valid = 0;
        #1;
        chk("t4_done", {grant, m1_write_ready, s_write_valid}, 4'b0000);

        // Test 5: read backpressure from m0
        issue(0, 0, 3'd3, 4'hF, 32'h0000_7000);
        handshake(0, "t5");
        s_read_valid = 1; s_read_data = 32'hE000_0000; m0_read_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall", {s_read_ack, m0_read_valid, grant}, 4'b0101);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            s_read_data = 32'hE000_0000 + i; m0_read_ack = 1;
            exp_rd0_q.push_back(32'hE000_0000 + i);
            #1;
            chk("t5_beat_grant", {s_read_ack, grant}, 3'b101);
            step();
        end
        s_read_valid = 0; m0_read_ack = 0;
        chk("t5_done", grant, 2'b00);

        // Test 6: reset during beat 2 of an m0 write
        issue(0, 1, 3'd3, 4'hF, 32'h0000_8000);
        handshake(0, "t6");
        m0_write_valid = 1; m0_write_data = 32'h1111_0000; s_write_ready = 1;
        exp_wr_q.push_back({2'b01, 32'h1111_0000, 1'b1, 1'b0});
        step();
        m0_write_data = 32'h1111_0001;
        rst_ni = 0;
        step();
        chk_reset_outputs("t6_reset");
        rst_ni = 1; m0_write_valid = 0; s_write_ready = 0;
        step();
        issue(1, 0, 3'd1, 4'h5, 32'h0000_9000);
        serve_read(1, 1, 32'hF000_0000, "t6b");

        step(); step();
        chk("sb_drain", exp_req_q.size() + exp_rd0_q.size() + exp_rd1_q.size() + exp_wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
